// File: rtl/vga_fb_write_sched.sv
// vga_fb_write_sched
// Arbitrates the single framebuffer write port between CPU pixel stores and
// a rectangle-fill engine. CPU writes always win; the fill stalls around them.
// Every accepted write shows up on FB_* one cycle later as a single-cycle pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for FILL_START; CPU writes pass straight through
// ST_FILL | walking the clipped rectangle, one pixel per free cycle
// ST_DONE | one-cycle completion pulse, then back to ST_IDLE

module vga_fb_write_sched #(
    parameter int H_RES = 80,
    parameter int V_RES = 60,
    parameter int XW    = 7,
    parameter int YW    = 6,
    parameter int DW    = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CPU_WE,
    input  logic [XW+YW-1:0]     CPU_WA,
    input  logic [DW-1:0]        CPU_WD,
    input  logic                 FILL_START,
    input  logic                 FILL_ABORT,
    input  logic [XW-1:0]        FILL_X0,
    input  logic [YW-1:0]        FILL_Y0,
    input  logic [XW-1:0]        FILL_W,
    input  logic [YW-1:0]        FILL_H,
    input  logic [DW-1:0]        FILL_COLOR,
    output logic [XW+YW-1:0]     FB_WA,
    output logic [DW-1:0]        FB_WD,
    output logic                 FB_WE,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam logic [XW:0] X_LIM = (XW+1)'(H_RES);
    localparam logic [YW:0] Y_LIM = (YW+1)'(V_RES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [XW-1:0]   x0_q;
    logic [XW:0]     xe_q;
    logic [YW:0]     ye_q;
    logic [DW-1:0]   color_q;

    logic [XW:0]     x_sum;
    logic [YW:0]     y_sum;
    logic [XW:0]     xe_calc;
    logic [YW:0]     ye_calc;
    logic            fill_empty;
    logic            x_last;
    logic            y_last;

    // Clipped end coordinates, one bit wider than the fields so the sum cannot wrap.
    always_comb begin
        x_sum      = {1'b0, FILL_X0} + {1'b0, FILL_W};
        y_sum      = {1'b0, FILL_Y0} + {1'b0, FILL_H};
        xe_calc    = (x_sum > X_LIM) ? X_LIM : x_sum;
        ye_calc    = (y_sum > Y_LIM) ? Y_LIM : y_sum;
        fill_empty = (FILL_W == '0) || (FILL_H == '0) ||
                     ({1'b0, FILL_X0} >= X_LIM) || ({1'b0, FILL_Y0} >= Y_LIM);
        x_last     = ({1'b0, x_q} == (xe_q - (XW+1)'(1)));
        y_last     = ({1'b0, y_q} == (ye_q - (YW+1)'(1)));
    end

    // Scheduler FSM with registered write port and status outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            color_q <= '0;
            FB_WA   <= '0;
            FB_WD   <= '0;
            FB_WE   <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            FB_WE <= 1'b0;
            DONE  <= 1'b0;

            // CPU store is never dropped, whatever the fill engine is doing.
            if (CPU_WE) begin
                FB_WE <= 1'b1;
                FB_WA <= CPU_WA;
                FB_WD <= CPU_WD;
            end

            case (state)
                ST_IDLE: begin
                    if (FILL_START) begin
                        x0_q    <= FILL_X0;
                        color_q <= FILL_COLOR;
                        xe_q    <= xe_calc;
                        ye_q    <= ye_calc;
                        x_q     <= FILL_X0;
                        y_q     <= FILL_Y0;
                        if (fill_empty) begin
                            state <= ST_DONE;
                            DONE  <= 1'b1;
                        end else begin
                            state <= ST_FILL;
                            BUSY  <= 1'b1;
                        end
                    end
                end

                ST_FILL: begin
                    if (FILL_ABORT) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else if (!CPU_WE) begin
                        FB_WE <= 1'b1;
                        FB_WA <= {y_q, x_q};
                        FB_WD <= color_q;
                        if (x_last) begin
                            x_q <= x0_q;
                            y_q <= y_q + YW'(1);
                        end else begin
                            x_q <= x_q + XW'(1);
                        end
                        if (x_last && y_last) begin
                            state <= ST_DONE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fb_write_sched.sv
// Directed bench for vga_fb_write_sched: CPU pass-through, fills with clipping,
// CPU stalls, abort and asynchronous reset mid-fill.

module tb_vga_fb_write_sched;

    logic        CLK;
    logic        RST_N;
    logic        CPU_WE;
    logic [12:0] CPU_WA;
    logic [7:0]  CPU_WD;
    logic        FILL_START;
    logic        FILL_ABORT;
    logic [6:0]  FILL_X0;
    logic [5:0]  FILL_Y0;
    logic [6:0]  FILL_W;
    logic [5:0]  FILL_H;
    logic [7:0]  FILL_COLOR;
    logic [12:0] FB_WA;
    logic [7:0]  FB_WD;
    logic        FB_WE;
    logic        BUSY;
    logic        DONE;

    int errors = 0;
    int checks = 0;

    logic [20:0] wr_q[$];
    logic [20:0] exp_q[$];
    int          busy_cnt;
    int          done_cnt;
    int          done_idx;

    vga_fb_write_sched dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .CPU_WE     (CPU_WE),
        .CPU_WA     (CPU_WA),
        .CPU_WD     (CPU_WD),
        .FILL_START (FILL_START),
        .FILL_ABORT (FILL_ABORT),
        .FILL_X0    (FILL_X0),
        .FILL_Y0    (FILL_Y0),
        .FILL_W     (FILL_W),
        .FILL_H     (FILL_H),
        .FILL_COLOR (FILL_COLOR),
        .FB_WA      (FB_WA),
        .FB_WD      (FB_WD),
        .FB_WE      (FB_WE),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs n cycles from a negedge. Each step samples the outputs left by the
    // previous posedge, then drives the inputs for the next one. Bit i of
    // cpu_mask drives a CPU store (WA=0, WD=FF) in step i; abort_at pulses abort.
    task automatic run(input bit do_start, input int n, input logic [31:0] cpu_mask,
                       input int abort_at);
        wr_q.delete();
        busy_cnt = 0;
        done_cnt = 0;
        done_idx = -1;
        for (int i = 0; i < n; i++) begin
            if (FB_WE === 1'b1) wr_q.push_back({FB_WA, FB_WD});
            if (BUSY === 1'b1) busy_cnt++;
            if (DONE === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            FILL_START = do_start && (i == 0);
            FILL_ABORT = (i == abort_at);
            CPU_WE     = cpu_mask[i];
            CPU_WA     = 13'h0000;
            CPU_WD     = 8'hFF;
            @(negedge CLK);
        end
        FILL_START = 1'b0;
        FILL_ABORT = 1'b0;
        CPU_WE     = 1'b0;
    endtask

    task automatic cmp_list(input string tag);
        logic [31:0] obs;
        chk({tag, " count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < wr_q.size()) ? {11'd0, wr_q[i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s wr%0d", tag, i), obs, {11'd0, exp_q[i]});
        end
    endtask

    task automatic set_fill(input logic [6:0] x0, input logic [5:0] y0,
                            input logic [6:0] w, input logic [5:0] h, input logic [7:0] c);
        FILL_X0    = x0;
        FILL_Y0    = y0;
        FILL_W     = w;
        FILL_H     = h;
        FILL_COLOR = c;
    endtask

    initial begin
        RST_N      = 1'b0;
        CPU_WE     = 1'b0;
        CPU_WA     = '0;
        CPU_WD     = '0;
        FILL_START = 1'b0;
        FILL_ABORT = 1'b0;
        set_fill(7'd0, 6'd0, 7'd0, 6'd0, 8'h00);

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst FB_WE", {31'd0, FB_WE}, 32'd0);
        chk("rst FB_WA", {19'd0, FB_WA}, 32'd0);
        chk("rst FB_WD", {24'd0, FB_WD}, 32'd0);
        chk("rst BUSY",  {31'd0, BUSY},  32'd0);
        chk("rst DONE",  {31'd0, DONE},  32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        // 1. CPU pass-through with one-cycle latency, single pulse
        CPU_WE = 1'b1; CPU_WA = 13'h0085; CPU_WD = 8'hE0;
        @(negedge CLK);
        CPU_WE = 1'b0;
        chk("cpu FB_WE", {31'd0, FB_WE}, 32'd1);
        chk("cpu FB_WA", {19'd0, FB_WA}, 32'h0085);
        chk("cpu FB_WD", {24'd0, FB_WD}, 32'hE0);
        @(negedge CLK);
        chk("cpu FB_WE low", {31'd0, FB_WE}, 32'd0);

        // 2. Basic 3x2 fill
        set_fill(7'd2, 6'd3, 7'd3, 6'd2, 8'h1C);
        run(1'b1, 10, 32'd0, -1);
        exp_q = '{{13'h0182, 8'h1C}, {13'h0183, 8'h1C}, {13'h0184, 8'h1C},
                  {13'h0202, 8'h1C}, {13'h0203, 8'h1C}, {13'h0204, 8'h1C}};
        cmp_list("fill");
        chk("fill busy", busy_cnt, 6);
        chk("fill done", done_cnt, 1);
        chk("fill done_idx", done_idx, 7);

        // 3. Clipped fill at the bottom-right corner
        set_fill(7'd78, 6'd59, 7'd10, 6'd10, 8'h55);
        run(1'b1, 6, 32'd0, -1);
        exp_q = '{{13'h1DCE, 8'h55}, {13'h1DCF, 8'h55}};
        cmp_list("clip");
        chk("clip busy", busy_cnt, 2);
        chk("clip done", done_cnt, 1);

        // 3b. Zero-width fill: DONE one cycle after START, no writes
        set_fill(7'd5, 6'd5, 7'd0, 6'd4, 8'h77);
        run(1'b1, 4, 32'd0, -1);
        exp_q = {};
        cmp_list("w0");
        chk("w0 busy", busy_cnt, 0);
        chk("w0 done_idx", done_idx, 1);

        // 3c. Origin outside the visible area
        set_fill(7'd80, 6'd0, 7'd4, 6'd4, 8'h77);
        run(1'b1, 4, 32'd0, -1);
        exp_q = {};
        cmp_list("x0oob");
        chk("x0oob done", done_cnt, 1);

        // 4. CPU stores on the 2nd pixel for two cycles stall the fill
        set_fill(7'd2, 6'd3, 7'd3, 6'd2, 8'h1C);
        run(1'b1, 12, 32'b1100, -1);
        exp_q = '{{13'h0182, 8'h1C}, {13'h0000, 8'hFF}, {13'h0000, 8'hFF},
                  {13'h0183, 8'h1C}, {13'h0184, 8'h1C}, {13'h0202, 8'h1C},
                  {13'h0203, 8'h1C}, {13'h0204, 8'h1C}};
        cmp_list("stall");
        chk("stall busy", busy_cnt, 8);
        chk("stall done", done_cnt, 1);

        // 5. Abort after 3 pixels, with a CPU store in the abort cycle
        run(1'b1, 10, 32'b1_0000, 4);
        exp_q = '{{13'h0182, 8'h1C}, {13'h0183, 8'h1C}, {13'h0184, 8'h1C},
                  {13'h0000, 8'hFF}};
        cmp_list("abort");
        chk("abort busy", busy_cnt, 4);
        chk("abort done", done_cnt, 0);
        chk("abort BUSY now", {31'd0, BUSY}, 32'd0);

        // 5b. New START accepted afterwards; ABORT alongside START in IDLE loses
        run(1'b1, 10, 32'd0, 0);
        exp_q = '{{13'h0182, 8'h1C}, {13'h0183, 8'h1C}, {13'h0184, 8'h1C},
                  {13'h0202, 8'h1C}, {13'h0203, 8'h1C}, {13'h0204, 8'h1C}};
        cmp_list("restart");
        chk("restart done", done_cnt, 1);

        // 6. Asynchronous reset mid-fill
        run(1'b1, 3, 32'd0, -1);
        chk("pre-rst BUSY", {31'd0, BUSY}, 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("mid-rst FB_WE", {31'd0, FB_WE}, 32'd0);
        chk("mid-rst FB_WA", {19'd0, FB_WA}, 32'd0);
        chk("mid-rst FB_WD", {24'd0, FB_WD}, 32'd0);
        chk("mid-rst BUSY",  {31'd0, BUSY},  32'd0);
        chk("mid-rst DONE",  {31'd0, DONE},  32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        run(1'b0, 8, 32'd0, -1);
        exp_q = {};
        cmp_list("post-rst");
        chk("post-rst busy", busy_cnt, 0);
        chk("post-rst done", done_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
